// File: rtl/obi_mem_arbiter.sv
// Two-master OBI arbiter onto one memory port.
// Round-robin with grant lock, in-order response routing via an ID FIFO.
module obi_mem_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int AW        = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      m_req_i,
  input  logic [2*AW-1:0] m_addr_i,
  input  logic [1:0]      m_we_i,
  input  logic [2*AW-1:0] m_wdata_i,
  output logic [1:0]      m_gnt_o,
  output logic [1:0]      m_rvalid_o,
  output logic [AW-1:0]   m_rdata_o,
  output logic            s_req_o,
  output logic [AW-1:0]   s_addr_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_wdata_o,
  input  logic            s_gnt_i,
  input  logic            s_rvalid_i,
  input  logic [AW-1:0]   s_rdata_i,
  output logic            err_o
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTST);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTST - 1);

  logic                 r_lock_v;
  logic                 r_lock_id;
  logic                 r_rr;
  logic [CW-1:0]        r_cnt;
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [MAX_OUTST-1:0] r_ids;
  logic                 r_err;

  logic w_sel;
  logic w_full;
  logic w_hs;
  logic w_pop;
  logic w_head;
  logic w_empty;

  // Reset pins the muxes to master 0; a held lock overrides arbitration.
  always_comb begin
    w_sel = 1'b0;
    if (!reset_n)
      w_sel = 1'b0;
    else if (r_lock_v)
      w_sel = r_lock_id;
    else if (&m_req_i)
      w_sel = r_rr;
    else
      w_sel = m_req_i[1];
  end

  assign w_full  = (r_cnt >= MAXC);
  assign w_empty = (r_cnt == '0);
  assign s_req_o = reset_n & (|m_req_i) & ~w_full;
  assign w_hs    = s_req_o & s_gnt_i;
  assign w_pop   = reset_n & s_rvalid_i & ~w_empty;
  assign w_head  = r_ids[r_rptr];

  assign s_addr_o  = w_sel ? m_addr_i[AW +: AW]  : m_addr_i[0 +: AW];
  assign s_wdata_o = w_sel ? m_wdata_i[AW +: AW] : m_wdata_i[0 +: AW];
  assign s_we_o    = w_sel ? m_we_i[1] : m_we_i[0];

  assign m_gnt_o    = {w_hs & w_sel, w_hs & ~w_sel};
  assign m_rvalid_o = {w_pop & w_head, w_pop & ~w_head};
  assign m_rdata_o  = s_rdata_i;
  assign err_o      = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_v  <= 1'b0;
      r_lock_id <= 1'b0;
      r_rr      <= 1'b0;
    end else begin
      if (s_req_o & ~s_gnt_i) begin
        r_lock_v  <= 1'b1;
        r_lock_id <= w_sel;
      end else if (w_hs) begin
        r_lock_v  <= 1'b0;
      end
      if (w_hs)
        r_rr <= ~w_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_ids  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_ids[r_wptr] <= w_sel;
        r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop)
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
      unique case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (s_rvalid_i & w_empty)
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter.
// Expected response routing is queued at grant time and checked on rvalid.
module tb_obi_mem_arbiter;

  localparam int AW = 32;

  logic            clk;
  logic            reset_n;
  logic [1:0]      m_req_i;
  logic [2*AW-1:0] m_addr_i;
  logic [1:0]      m_we_i;
  logic [2*AW-1:0] m_wdata_i;
  logic [1:0]      m_gnt_o;
  logic [1:0]      m_rvalid_o;
  logic [AW-1:0]   m_rdata_o;
  logic            s_req_o;
  logic [AW-1:0]   s_addr_o;
  logic            s_we_o;
  logic [AW-1:0]   s_wdata_o;
  logic            s_gnt_i;
  logic            s_rvalid_i;
  logic [AW-1:0]   s_rdata_i;
  logic            err_o;

  int n_chk = 0;
  int n_err = 0;

  int          q_id[$];
  logic [31:0] q_dat[$];

  obi_mem_arbiter #(.MAX_OUTST(2), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i),
    .m_we_i(m_we_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o),
    .s_we_o(s_we_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    m_req_i    = 2'b00;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    q_id.delete();
    q_dat.delete();
  endtask

  task automatic test_reset();
    m_req_i    = 2'b10;
    s_rvalid_i = 1'b1;
    #1;
    n_chk++;
    if (s_req_o !== 1'b0 || m_gnt_o !== 2'b00) begin
      n_err++;
      $display("FAIL rst_req got=%b/%b exp=0/00", s_req_o, m_gnt_o);
    end
    n_chk++;
    if (m_rvalid_o !== 2'b00 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rv got=%b/%b exp=00/0", m_rvalid_o, err_o);
    end
    n_chk++;
    if (s_addr_o !== 32'h100) begin
      n_err++;
      $display("FAIL rst_mux got=%h exp=100", s_addr_o);
    end
    @(posedge clk);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int e_id;
    logic [31:0] e_d;
    logic [1:0] e_rv;
    m_addr_i[31:0] = 32'h10;
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    #1;
    n_chk++;
    if (m_gnt_o !== 2'b01 || s_addr_o !== 32'h10) begin
      n_err++;
      $display("FAIL single_gnt got=%b/%h exp=01/10", m_gnt_o, s_addr_o);
    end
    q_id.push_back(0);
    q_dat.push_back(32'h13);
    cyc();
    idle();
    e_id = q_id.pop_front();
    e_d  = q_dat.pop_front();
    e_rv = (e_id == 1) ? 2'b10 : 2'b01;
    s_rvalid_i = 1'b1;
    s_rdata_i  = e_d;
    #1;
    n_chk++;
    if (m_rvalid_o !== e_rv || m_rdata_o !== e_d) begin
      n_err++;
      $display("FAIL single_rsp got=%b/%h exp=%b/%h", m_rvalid_o, m_rdata_o, e_rv, e_d);
    end
    cyc();
    idle();
    m_addr_i[31:0] = 32'h100;
    n_chk++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_err got=%b exp=0", err_o);
    end
  endtask

  task automatic test_round_robin();
    int e_id;
    logic [31:0] e_d;
    logic [1:0] e_rv;
    logic [1:0] e_g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_req_i = 2'b11;
      s_gnt_i = 1'b1;
      s_rvalid_i = 1'b0;
      e_rv = 2'b00;
      e_d = '0;
      if (i > 0) begin
        e_id = q_id.pop_front();
        e_d  = q_dat.pop_front();
        e_rv = (e_id == 1) ? 2'b10 : 2'b01;
        s_rvalid_i = 1'b1;
        s_rdata_i  = e_d;
      end
      e_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_chk++;
      if (m_gnt_o !== e_g) begin
        n_err++;
        $display("FAIL rr_gnt%0d got=%b exp=%b", i, m_gnt_o, e_g);
      end
      if (i > 0) begin
        n_chk++;
        if (m_rvalid_o !== e_rv || m_rdata_o !== e_d) begin
          n_err++;
          $display("FAIL rr_rsp%0d got=%b/%h exp=%b/%h", i, m_rvalid_o, m_rdata_o, e_rv, e_d);
        end
      end
      q_id.push_back(i % 2);
      q_dat.push_back($urandom);
      cyc();
    end
    idle();
    e_id = q_id.pop_front();
    e_d  = q_dat.pop_front();
    e_rv = (e_id == 1) ? 2'b10 : 2'b01;
    s_rvalid_i = 1'b1;
    s_rdata_i  = e_d;
    #1;
    n_chk++;
    if (m_rvalid_o !== e_rv || m_rdata_o !== e_d) begin
      n_err++;
      $display("FAIL rr_last got=%b/%h exp=%b/%h", m_rvalid_o, m_rdata_o, e_rv, e_d);
    end
    cyc();
    idle();
  endtask

  task automatic test_lock();
    int e_id;
    logic [31:0] e_d;
    logic [1:0] e_rv;
    do_reset();
    m_req_i = 2'b11;
    #1;
    n_chk++;
    if (s_addr_o !== 32'h100 || m_gnt_o !== 2'b00) begin
      n_err++;
      $display("FAIL lock_start got=%h/%b exp=100/00", s_addr_o, m_gnt_o);
    end
    cyc();
    for (int i = 0; i < 2; i++) begin
      m_req_i = 2'b10;
      #1;
      n_chk++;
      if (s_addr_o !== 32'h100 || s_req_o !== 1'b1) begin
        n_err++;
        $display("FAIL lock_hold%0d got=%h/%b exp=100/1", i, s_addr_o, s_req_o);
      end
      cyc();
    end
    s_gnt_i = 1'b1;
    #1;
    n_chk++;
    if (s_addr_o !== 32'h100 || m_gnt_o !== 2'b01) begin
      n_err++;
      $display("FAIL lock_gnt got=%h/%b exp=100/01", s_addr_o, m_gnt_o);
    end
    q_id.push_back(0);
    q_dat.push_back(32'hA5A5_0001);
    cyc();
    s_gnt_i = 1'b0;
    #1;
    n_chk++;
    if (s_addr_o !== 32'h200) begin
      n_err++;
      $display("FAIL lock_clear got=%h exp=200", s_addr_o);
    end
    cyc();
    idle();
    e_id = q_id.pop_front();
    e_d  = q_dat.pop_front();
    e_rv = (e_id == 1) ? 2'b10 : 2'b01;
    s_rvalid_i = 1'b1;
    s_rdata_i  = e_d;
    #1;
    n_chk++;
    if (m_rvalid_o !== e_rv || m_rdata_o !== e_d) begin
      n_err++;
      $display("FAIL lock_rsp got=%b/%h exp=%b/%h", m_rvalid_o, m_rdata_o, e_rv, e_d);
    end
    cyc();
    idle();
  endtask

  task automatic test_outstanding();
    int e_id;
    logic [31:0] e_d;
    logic [1:0] e_rv;
    do_reset();
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    #1;
    n_chk++;
    if (s_req_o !== 1'b1 || m_gnt_o !== 2'b01) begin
      n_err++;
      $display("FAIL out_g1 got=%b/%b exp=1/01", s_req_o, m_gnt_o);
    end
    q_id.push_back(0);
    q_dat.push_back(32'h1111_0000);
    cyc();
    m_req_i = 2'b10;
    #1;
    n_chk++;
    if (s_req_o !== 1'b1 || m_gnt_o !== 2'b10) begin
      n_err++;
      $display("FAIL out_g2 got=%b/%b exp=1/10", s_req_o, m_gnt_o);
    end
    q_id.push_back(1);
    q_dat.push_back(32'h2222_0000);
    cyc();
    m_req_i = 2'b01;
    #1;
    n_chk++;
    if (s_req_o !== 1'b0 || m_gnt_o !== 2'b00) begin
      n_err++;
      $display("FAIL out_full got=%b/%b exp=0/00", s_req_o, m_gnt_o);
    end
    cyc();
    e_id = q_id.pop_front();
    e_d  = q_dat.pop_front();
    e_rv = (e_id == 1) ? 2'b10 : 2'b01;
    s_rvalid_i = 1'b1;
    s_rdata_i  = e_d;
    #1;
    n_chk++;
    if (s_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL out_nopath got=%b exp=0", s_req_o);
    end
    n_chk++;
    if (m_rvalid_o !== e_rv || m_rdata_o !== e_d) begin
      n_err++;
      $display("FAIL out_rsp1 got=%b/%h exp=%b/%h", m_rvalid_o, m_rdata_o, e_rv, e_d);
    end
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    n_chk++;
    if (s_req_o !== 1'b1 || m_gnt_o !== 2'b01) begin
      n_err++;
      $display("FAIL out_resume got=%b/%b exp=1/01", s_req_o, m_gnt_o);
    end
    q_id.push_back(0);
    q_dat.push_back(32'h3333_0000);
    cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      e_id = q_id.pop_front();
      e_d  = q_dat.pop_front();
      e_rv = (e_id == 1) ? 2'b10 : 2'b01;
      s_rvalid_i = 1'b1;
      s_rdata_i  = e_d;
      #1;
      n_chk++;
      if (m_rvalid_o !== e_rv || m_rdata_o !== e_d) begin
        n_err++;
        $display("FAIL out_order%0d got=%b/%h exp=%b/%h", i, m_rvalid_o, m_rdata_o, e_rv, e_d);
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_error();
    do_reset();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if (m_rvalid_o !== 2'b00 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_pre got=%b/%b exp=00/0", m_rvalid_o, err_o);
    end
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (err_o !== 1'b1) begin
        n_err++;
        $display("FAIL err_sticky%0d got=%b exp=1", i, err_o);
      end
      cyc();
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr got=%b exp=0", err_o);
    end
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int e_id;
    logic [31:0] e_d;
    logic [1:0] e_rv;
    logic [1:0] e_g;
    do_reset();
    m_req_i = 2'b11;
    s_gnt_i = 1'b1;
    cyc();
    cyc();
    q_id.delete();
    q_dat.delete();
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (s_req_o !== 1'b0 || m_gnt_o !== 2'b00) begin
      n_err++;
      $display("FAIL mid_rst got=%b/%b exp=0/00", s_req_o, m_gnt_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    s_rvalid_i = 1'b1;
    #1;
    n_chk++;
    if (m_rvalid_o !== 2'b00) begin
      n_err++;
      $display("FAIL mid_stale got=%b exp=00", m_rvalid_o);
    end
    cyc();
    s_rvalid_i = 1'b0;
    #1;
    n_chk++;
    if (err_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_err got=%b exp=1", err_o);
    end
    for (int i = 0; i < 2; i++) begin
      m_req_i = 2'b11;
      s_gnt_i = 1'b1;
      e_g = (i == 0) ? 2'b01 : 2'b10;
      #1;
      n_chk++;
      if (s_req_o !== 1'b1 || m_gnt_o !== e_g) begin
        n_err++;
        $display("FAIL mid_gnt%0d got=%b/%b exp=1/%b", i, s_req_o, m_gnt_o, e_g);
      end
      q_id.push_back(i);
      q_dat.push_back($urandom);
      cyc();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      e_id = q_id.pop_front();
      e_d  = q_dat.pop_front();
      e_rv = (e_id == 1) ? 2'b10 : 2'b01;
      s_rvalid_i = 1'b1;
      s_rdata_i  = e_d;
      #1;
      n_chk++;
      if (m_rvalid_o !== e_rv || m_rdata_o !== e_d) begin
        n_err++;
        $display("FAIL mid_rsp%0d got=%b/%h exp=%b/%h", i, m_rvalid_o, m_rdata_o, e_rv, e_d);
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    reset_n   = 1'b0;
    m_addr_i  = {32'h200, 32'h100};
    m_wdata_i = {32'hBBBB_0002, 32'hAAAA_0001};
    m_we_i    = 2'b00;
    idle();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
